muldiv_hilo_ctrl: RTL and testbench

Iterative multiply/divide sequencer owning the HI/LO register pair for the multi-cycle CPU datapath. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the decode stage and runs a WIDTH-iteration shift-add multiply or restoring divide. It exposes a busy/done handshake so the control unit can stall dependent MFHI/MFLO. This moves 64-bit multiply and divide out of the combinational ALU path and onto a bounded-latency sequential unit.

---
 rtl/muldiv_hilo_ctrl.sv | 169 ++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO pair: WIDTH-step shift-add
// multiply or restoring divide, with MTHI/MTLO writes and a busy/done handshake.
module muldiv_hilo_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]    a_q, a_d;      // |multiplicand|, or |dividend| shifted out MSB first
  logic [WIDTH-1:0]    b_q, b_d;      // |multiplier| shifted out LSB first, or |divisor|
  logic                is_div_q, is_div_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                done_q, done_d;

  // Datapath for one iteration of each algorithm.
  logic [WIDTH:0]      mul_sum;
  logic [WIDTH:0]      div_trial;
  logic [WIDTH:0]      div_diff;
  logic                div_ge;
  logic [WIDTH-1:0]    div_rem;
  logic [2*WIDTH-1:0]  prod_fix;
  logic [WIDTH-1:0]    quo;
  logic [WIDTH-1:0]    rem;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
  assign div_ge    = (div_trial >= {1'b0, b_q});
  assign div_diff  = div_trial - {1'b0, b_q};
  assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];

  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];
  assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              sign_a_d = ~op[0] & rs[WIDTH-1];
              sign_b_d = ~op[0] & rt[WIDTH-1];
              a_d      = sign_a_d ? -rs : rs;
              b_d      = sign_b_d ? -rt : rt;
              is_div_d = op[1];
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = S_RUN;
            end
            OP_MTHI: hi_d = rs;
            OP_MTLO: lo_d = rs;
            default: ;
          endcase
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
          a_d   = a_q << 1;
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        if (is_div_q) begin
          // With a zero divisor every trial subtract succeeds, so rem already
          // holds |rs| and the signed fix-up restores the raw dividend.
          lo_d = (b_q == '0) ? '1 : ((sign_a_q ^ sign_b_q) ? -quo : quo);
          hi_d = sign_a_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its _d regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl: directed vector table, handshake/abort
// sequences, and randomized ops checked against a plain-arithmetic reference model.
module tb_muldiv_hilo_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rs;
  logic [W-1:0] rt;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  muldiv_hilo_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: {hi, lo} from the architectural definition using wide arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint       sa;
    longint       sb;
    logic [63:0]  q;
    logic [63:0]  r;
    logic [63:0]  res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (o)
      3'd0: res = sa * sb;
      3'd1: res = {32'b0, a} * {32'b0, b};
      3'd2, 3'd3: begin
        if (b == 0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          if (o == 3'd2) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = {32'b0, a / b};
            r = {32'b0, a % b};
          end
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = {m_hi, m_lo};
    endcase
    return res;
  endfunction

  // Entered at a negedge; returns at the negedge where done is high.
  task automatic run_muldiv(input logic [2:0] op_i, input logic [W-1:0] rs_i,
                            input logic [W-1:0] rt_i, input logic [63:0] exp,
                            input string name);
    int busy_cnt;
    int done_cnt;
    int overlap;
    busy_cnt = 0;
    done_cnt = 0;
    overlap  = 0;
    start = 1'b1;
    op    = op_i;
    rs    = rs_i;
    rt    = rt_i;
    @(negedge clk);
    start = 1'b0;
    op    = 3'($urandom_range(0, 3));
    rs    = $urandom;
    rt    = $urandom;
    for (int i = 0; i < 60; i++) begin
      if (busy && done) overlap++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        break;
      end
      if (i < 32) check({name, " hi_hold"}, {hi, lo}, {m_hi, m_lo});
      @(negedge clk);
    end
    check({name, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({name, " done_seen"}, 64'(done_cnt), 64'd1);
    check({name, " busy_done_overlap"}, 64'(overlap), 64'd0);
    check({name, " hi"}, 64'(hi), 64'(exp[63:32]));
    check({name, " lo"}, 64'(lo), 64'(exp[31:0]));
    {m_hi, m_lo} = exp;
  endtask

  // MTHI/MTLO or no-op; entered at a negedge, returns at the next negedge.
  task automatic move_op(input logic [2:0] op_i, input logic [W-1:0] rs_i, input string name);
    start = 1'b1;
    op    = op_i;
    rs    = rs_i;
    if (op_i == 3'd4) m_hi = rs_i;
    if (op_i == 3'd5) m_lo = rs_i;
    @(posedge clk);
    #1;
    check({name, " hilo"}, {hi, lo}, {m_hi, m_lo});
    check({name, " busy_done"}, {62'b0, busy, done}, 64'd0);
    @(negedge clk);
    start = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    int done_seen;
    int busy_seen;
    logic [2:0]   r_op;
    logic [W-1:0] r_rs;
    logic [W-1:0] r_rt;

    vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[7] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[9] = '{3'd1, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};

    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    rs    = '0;
    rt    = '0;
    m_hi  = '0;
    m_lo  = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'b0, busy, done}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {30'b0, busy, done, hi}, 64'd0);

    // Directed table, issued back-to-back: each start lands in the previous done cycle.
    foreach (vecs[i]) begin
      run_muldiv(vecs[i].op, vecs[i].rs, vecs[i].rt, {vecs[i].exp_hi, vecs[i].exp_lo},
                 $sformatf("vec%0d", i));
    end
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);

    move_op(3'd5, 32'h0000_1234, "mtlo");
    check("mtlo_no_done", 64'(done), 64'd0);
    move_op(3'd4, 32'hCAFE_F00D, "mthi");
    move_op(3'd6, 32'h1111_1111, "noop6");
    move_op(3'd7, 32'h2222_2222, "noop7");

    // MTHI held high while busy must be dropped; hi changes only at FINISH.
    start = 1'b1;
    op    = 3'd0;
    rs    = 32'd6;
    rt    = 32'd7;
    @(negedge clk);
    op = 3'd4;
    rs = 32'hDEAD_BEEF;
    check("mthi_busy_running", 64'(busy), 64'd1);
    repeat (5) @(negedge clk);
    check("mthi_busy_hi_hold", 64'(hi), 64'(m_hi));
    start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 60 && done_seen == 0; i++) begin
      if (done) done_seen = 1;
      else @(negedge clk);
    end
    check("mthi_busy_done", 64'(done_seen), 64'd1);
    check("mthi_busy_result", {hi, lo}, 64'd42);
    {m_hi, m_lo} = 64'd42;
    @(negedge clk);
    check("mthi_busy_not_queued", {hi, lo}, 64'd42);

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      r_op = 3'($urandom_range(0, 7));
      r_rs = $urandom;
      r_rt = $urandom;
      case ($urandom_range(0, 5))
        0: r_rt = '0;
        1: r_rt = 32'($urandom_range(1, 9));
        2: r_rs = 32'h8000_0000;
        3: r_rt = 32'hFFFF_FFFF;
        default: ;
      endcase
      if (r_op <= 3'd3)
        run_muldiv(r_op, r_rs, r_rt, ref_md(r_op, r_rs, r_rt), $sformatf("rnd%0d", n));
      else begin
        if (done) @(negedge clk);
        move_op(r_op, r_rs, $sformatf("rnd%0d", n));
      end
    end
    @(negedge clk);

    // Reset asserted around RUN iteration 10 aborts without a done pulse.
    start = 1'b1;
    op    = 3'd1;
    rs    = 32'h1234_5678;
    rt    = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_still_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_async_hilo", {hi, lo}, 64'd0);
    check("abort_async_busy_done", {62'b0, busy, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_stays_idle", 64'(busy_seen), 64'd0);
    check("abort_hilo_zero", {hi, lo}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
